fir_seq_ctrl: RTL and testbench
===============================

# fir_seq_ctrl

Time-multiplexed FIR engine controller: sequences a single shared multiply-accumulate unit across N_TAPS taps per input sample, replacing the fully parallel tap multipliers used elsewhere in the filter path. It owns the sample delay line and a run-time-writable coefficient bank, and talks to its neighbours over valid/ready streams. It sits between the sample source (ADC front-end/decimator) and the downstream consumer, with a small config port driven by the register block.

## Interface
- N_TAPS, 4, number of taps (≥2)
- DATA_W, 8, signed sample width
- COEF_W, 8, signed coefficient width
- ACC_W, 16, signed accumulator/output width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- s_valid  in  1  input sample valid
- s_ready  out  1  block can accept a sample
- s_data  in  DATA_W  signed input sample
- m_valid  out  1  output result valid
- m_ready  in  1  consumer accepts result
- m_data  out  ACC_W  signed filter output
- cfg_we  in  1  coefficient write request
- cfg_ready  out  1  coefficient write can be taken this cycle
- cfg_addr  in  clog2(N_TAPS)  coefficient index
- cfg_data  in  COEF_W  signed coefficient value
- busy  out  1  high in MAC or OUT state

## Operation
- FSM states: IDLE, MAC, OUT. Reset state IDLE.
- IDLE: s_ready = 1, cfg_ready = 1. On s_valid && s_ready: x[k] <= x[k-1] for k = N_TAPS-1 down to 1, x[0] <= s_data, acc <= 0, tap index k <= 0, go to MAC.
- MAC: one tap per cycle, acc <= acc + h[k]*x[k], k <= k+1. On the cycle with k = N_TAPS-1: m_data <= final sum, m_valid <= 1, go to OUT.
- OUT: m_valid held high and m_data held stable until m_ready; on m_valid && m_ready: m_valid <= 0, go to IDLE.
- Arithmetic: product is sign-extended to ACC_W; accumulation is two's-complement wrap modulo 2^ACC_W, with no saturation.
- Config: write occurs on cfg_we && cfg_ready (IDLE only); h[cfg_addr] <= cfg_data. cfg_we outside IDLE is dropped. cfg_addr ≥ N_TAPS is ignored.
- Simultaneous sample accept and cfg write in IDLE: both taken at the same edge; the new coefficient is used by that sample's MAC pass.
- s_ready = cfg_ready = (state == IDLE) && !reset; busy = (state != IDLE).

## Timing
- Reset values:
  - x[] = 0, acc = 0, k = 0, m_data = 0, m_valid = 0, busy = 0, state IDLE.
  - h[k] = (k+1) truncated to COEF_W, giving 1,2,3,4 at default N_TAPS.
  - s_ready = 0 and cfg_ready = 0 while reset is high.
- Latency: sample accepted at edge E0 → m_valid high after edge E0+N_TAPS.
- Throughput: with m_ready held high, one sample per N_TAPS+2 cycles (1 IDLE, N_TAPS MAC, 1 OUT).
- Backpressure: while m_ready is low the block stays in OUT, s_ready stays low, and no sample is lost or overwritten.
- Reset mid-MAC or in OUT: the partial sum and pending result are discarded, the delay line is cleared, and the coefficients return to their reset values.

## Structure
- Package fir_pkg:
  - state enum (IDLE, MAC, OUT);
  - default width constants DATA_W/COEF_W/ACC_W/N_TAPS;
  - function coef_init(k) returning the reset coefficient.
- Sub-module fir_mac_unit: a registered signed multiply-accumulate with clr and en inputs, holding acc. The FSM, tap counter, delay line, and coefficient bank stay in fir_seq_ctrl.

## Test plan
- Reset defaults, m_ready = 1, samples 5, 10, 0, 4, -2 → m_data 5, 20, 35, 54, 46; each m_valid asserted exactly N_TAPS cycles after its accept edge.
- Backpressure: hold m_ready = 0 for 10 cycles after the first result → m_data stable, m_valid high, s_ready low throughout; release → result consumed and next sample accepted.
- Config write: from reset, write h[0] = 0xFF (-1) in IDLE, then sample 3 → m_data = 0xFFFD (-3). A cfg_we during MAC is dropped, and the next result is unchanged.
- Wrap: all h = 127, four samples of -128 → fourth m_data = 0x0200 (512, i.e. -65024 mod 2^16).
- Simultaneous accept and write: in the same IDLE cycle, write h[0] = 2 and present sample 7 → m_data = 14.
- Reset asserted on the second MAC cycle → all outputs at reset values immediately; after release, sample 5 → m_data = 5 (delay line cleared, default coefficients).

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and defaults for the time-multiplexed FIR controller.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  localparam int DEF_N_TAPS = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_COEF_W = 8;
  localparam int DEF_ACC_W  = 16;

  // Reset coefficient for tap k; callers truncate to their coefficient width.
  function automatic int coef_init(input int k);
    return k + 1;
  endfunction

endpackage

// File: rtl/fir_seq_ctrl_if.sv
// Sample-in / result-out streams plus coefficient config port of the FIR controller.
interface fir_seq_ctrl_if
  import fir_pkg::*;
#(
  parameter int N_TAPS = DEF_N_TAPS,
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int ACC_W  = DEF_ACC_W
);
  localparam int ADDR_W = $clog2(N_TAPS);

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [ACC_W-1:0]  m_data;
  logic              cfg_we;
  logic              cfg_ready;
  logic [ADDR_W-1:0] cfg_addr;
  logic [COEF_W-1:0] cfg_data;
  logic              busy;

  // slave is the controller; master is the sample source, result sink and register block.
  modport slave (
    input  s_valid, s_data, m_ready, cfg_we, cfg_addr, cfg_data,
    output s_ready, m_valid, m_data, cfg_ready, busy
  );

  modport master (
    output s_valid, s_data, m_ready, cfg_we, cfg_addr, cfg_data,
    input  s_ready, m_valid, m_data, cfg_ready, busy
  );

endinterface

// File: rtl/fir_mac_unit.sv
// Registered signed multiply-accumulate; sum is the value acc takes on an enabled edge.
module fir_mac_unit #(
  parameter int A_W   = 8,
  parameter int B_W   = 8,
  parameter int ACC_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic signed [ACC_W-1:0] sum
);
  localparam int P_W = A_W + B_W;

  logic signed [P_W-1:0]   prod;
  logic signed [ACC_W-1:0] acc_reg;

  assign prod = a * b;
  // Sign-extended product, two's-complement wrap on overflow.
  assign sum  = acc_reg + ACC_W'(prod);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_reg <= '0;
    end else if (clr) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= sum;
    end
  end

endmodule

// File: rtl/fir_seq_ctrl.sv
// FIR controller: one shared MAC walks N_TAPS taps per accepted sample, owning
// the delay line and a run-time-writable coefficient bank.
module fir_seq_ctrl
  import fir_pkg::*;
#(
  parameter int N_TAPS = DEF_N_TAPS,
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input logic           clk,
  input logic           reset,
  fir_seq_ctrl_if.slave bus
);
  localparam int ADDR_W = $clog2(N_TAPS);
  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(N_TAPS - 1);

  state_t                  state_reg;
  logic [ADDR_W-1:0]       k_reg;
  logic [ACC_W-1:0]        m_data_reg;
  logic                    m_valid_reg;
  logic                    busy_reg;
  logic signed [DATA_W-1:0] x_reg [N_TAPS];
  logic signed [COEF_W-1:0] h_reg [N_TAPS];

  logic                    idle_ready;
  logic                    accept;
  logic                    cfg_take;
  logic [N_TAPS-1:0]       h_we;
  logic signed [ACC_W-1:0] mac_sum;

  assign idle_ready = (state_reg == IDLE) && !reset;
  assign accept     = idle_ready && bus.s_valid;
  assign cfg_take   = idle_ready && bus.cfg_we;

  // Out-of-range addresses match no tap and are therefore ignored.
  for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_coef_we
    assign h_we[gi] = cfg_take && (bus.cfg_addr == ADDR_W'(gi));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_TAPS; i++) begin
        x_reg[i] <= '0;
        h_reg[i] <= COEF_W'(coef_init(i));
      end
    end else begin
      if (accept) begin
        x_reg[0] <= $signed(bus.s_data);
        for (int i = 1; i < N_TAPS; i++) begin
          x_reg[i] <= x_reg[i-1];
        end
      end
      for (int i = 0; i < N_TAPS; i++) begin
        if (h_we[i]) begin
          h_reg[i] <= $signed(bus.cfg_data);
        end
      end
    end
  end

  fir_mac_unit #(
    .A_W   (DATA_W),
    .B_W   (COEF_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .en    (state_reg == MAC),
    .a     (x_reg[k_reg]),
    .b     (h_reg[k_reg]),
    .sum   (mac_sum)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      k_reg       <= '0;
      m_data_reg  <= '0;
      m_valid_reg <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            k_reg     <= '0;
            busy_reg  <= 1'b1;
            state_reg <= MAC;
          end
        end
        MAC: begin
          k_reg <= k_reg + 1'b1;
          if (k_reg == LAST_TAP) begin
            m_data_reg  <= mac_sum;
            m_valid_reg <= 1'b1;
            state_reg   <= OUT;
          end
        end
        OUT: begin
          if (bus.m_ready) begin
            m_valid_reg <= 1'b0;
            busy_reg    <= 1'b0;
            state_reg   <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_ready   = idle_ready;
  assign bus.cfg_ready = idle_ready;
  assign bus.m_valid   = m_valid_reg;
  assign bus.m_data    = m_data_reg;
  assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Randomized bench for fir_seq_ctrl against a convolution model of the filter.
module tb_fir_seq_ctrl;
  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int CW  = 8;
  localparam int AW  = 16;
  localparam int ADW = $clog2(N);

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fir_seq_ctrl_if #(.N_TAPS(N), .DATA_W(DW), .COEF_W(CW), .ACC_W(AW)) bus ();

  fir_seq_ctrl #(.N_TAPS(N), .DATA_W(DW), .COEF_W(CW), .ACC_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int last_acc = 0;
  bit b2b_ok   = 1'b0;
  int mh [N];
  int mx [N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin
      mh[k] = int'($signed(CW'(k + 1)));
      mx[k] = 0;
    end
  endfunction

  // y = sum_k h[k] * x[n-k], reduced modulo 2^AW.
  function automatic logic [AW-1:0] model_push(input int s);
    int sum = 0;
    for (int k = N - 1; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = s;
    for (int k = 0; k < N; k++) sum += mh[k] * mx[k];
    return AW'(sum);
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    b2b_ok = 1'b0;
  endtask

  task automatic cfg_write(input int addr, input int data);
    int w = 0;
    while (bus.cfg_ready !== 1'b1 && w < 50) begin tick(); w++; end
    check("cfg_ready", 32'(bus.cfg_ready), 32'd1);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = ADW'(addr);
    bus.cfg_data = CW'(data);
    tick();
    bus.cfg_we = 1'b0;
    if (addr < N) mh[addr] = int'($signed(CW'(data)));
    b2b_ok = 1'b0;
    $display("cfg write h[%0d] = %0d", addr, int'($signed(CW'(data))));
  endtask

  task automatic send(input int s, input int bp, input bit with_cfg, input int caddr,
                      input int cdata, input bit mid_cfg, output logic [AW-1:0] got);
    logic [AW-1:0] exp;
    int w = 0;
    int lat = 0;
    bus.m_ready = (bp == 0);
    while (bus.s_ready !== 1'b1 && w < 50) begin tick(); w++; end
    check("s_ready_idle", 32'(bus.s_ready), 32'd1);
    bus.s_valid = 1'b1;
    bus.s_data  = DW'(s);
    if (with_cfg) begin
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = ADW'(caddr);
      bus.cfg_data = CW'(cdata);
    end
    tick();
    bus.s_valid = 1'b0;
    bus.cfg_we  = 1'b0;
    if (b2b_ok && w == 0) check("throughput", 32'(cyc - last_acc), 32'(N + 2));
    last_acc = cyc;
    if (with_cfg && caddr < N) mh[caddr] = int'($signed(CW'(cdata)));
    exp = model_push(s);
    check("busy_mac", 32'(bus.busy), 32'd1);
    check("s_ready_mac", 32'(bus.s_ready), 32'd0);
    while (bus.m_valid !== 1'b1 && lat < 40) begin
      if (mid_cfg && lat == 1) begin
        check("cfg_ready_mac", 32'(bus.cfg_ready), 32'd0);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = ADW'(0);
        bus.cfg_data = CW'(8'h55);
      end else begin
        bus.cfg_we = 1'b0;
      end
      tick();
      lat++;
    end
    bus.cfg_we = 1'b0;
    check("latency", 32'(lat), 32'(N));
    got = bus.m_data;
    check("m_data", 32'(bus.m_data), 32'(exp));
    for (int i = 0; i < bp; i++) begin
      tick();
      check("bp_m_valid", 32'(bus.m_valid), 32'd1);
      check("bp_m_data", 32'(bus.m_data), 32'(exp));
      check("bp_s_ready", 32'(bus.s_ready), 32'd0);
    end
    bus.m_ready = 1'b1;
    tick();
    check("consumed_m_valid", 32'(bus.m_valid), 32'd0);
    check("consumed_s_ready", 32'(bus.s_ready), 32'd1);
    check("consumed_busy", 32'(bus.busy), 32'd0);
    b2b_ok = (bp == 0);
    $display("sample %0d -> m_data 0x%04h (expected 0x%04h) latency %0d bp %0d",
             s, got, exp, lat, bp);
  endtask

  initial begin
    logic [AW-1:0] got;
    int seq_in  [5] = '{5, 10, 0, 4, -2};
    int seq_out [5] = '{5, 20, 35, 54, 46};

    bus.s_valid  = 1'b0;
    bus.s_data   = '0;
    bus.m_ready  = 1'b0;
    bus.cfg_we   = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", 32'(bus.s_ready), 32'd0);
    check("rst_cfg_ready", 32'(bus.cfg_ready), 32'd0);
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_m_data", 32'(bus.m_data), 32'd0);
    reset = 1'b0;
    model_reset();

    for (int i = 0; i < 5; i++) begin
      send(seq_in[i], 0, 1'b0, 0, 0, 1'b0, got);
      check("directed_seq", 32'(got), 32'(AW'(seq_out[i])));
    end

    send(7, 10, 1'b0, 0, 0, 1'b0, got);
    send(1, 0, 1'b0, 0, 0, 1'b0, got);

    do_reset();
    cfg_write(0, 8'hFF);
    send(3, 0, 1'b0, 0, 0, 1'b0, got);
    check("neg_coef", 32'(got), 32'h0000FFFD);
    send(6, 0, 1'b0, 0, 0, 1'b1, got);
    send(2, 0, 1'b0, 0, 0, 1'b0, got);

    do_reset();
    for (int k = 0; k < N; k++) cfg_write(k, 127);
    for (int i = 0; i < 4; i++) send(-128, 0, 1'b0, 0, 0, 1'b0, got);
    check("wrap", 32'(got), 32'h00000200);

    do_reset();
    send(7, 0, 1'b1, 0, 2, 1'b0, got);
    check("simul_cfg", 32'(got), 32'd14);

    // Reset on the second MAC cycle, then a fresh sample.
    bus.s_valid = 1'b1;
    bus.s_data  = DW'(9);
    tick();
    bus.s_valid = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check("midrst_m_valid", 32'(bus.m_valid), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_s_ready", 32'(bus.s_ready), 32'd0);
    check("midrst_cfg_ready", 32'(bus.cfg_ready), 32'd0);
    check("midrst_m_data", 32'(bus.m_data), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    b2b_ok = 1'b0;
    send(5, 0, 1'b0, 0, 0, 1'b0, got);
    check("after_midrst", 32'(got), 32'd5);

    for (int t = 0; t < 40; t++) begin
      int s;
      int bp;
      s  = int'($signed(DW'($urandom_range(0, 255))));
      bp = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
      if ($urandom_range(0, 3) == 0) cfg_write(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 255)));
      send(s, bp, ($urandom_range(0, 4) == 0), int'($urandom_range(0, N - 1)),
           int'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0), got);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
